flt2fix_seq: RTL
================

# flt2fix_seq

Parametrised sequential converter from a packed binary floating-point word (sign, biased exponent, fraction) to a two's-complement fixed-point word. It is the hardware successor to the team's float-to-fix 8.8 software program. It is reused as a coprocessor beside the core datapath and uses the same start/ack handshake as the top level. Defaults reproduce half-precision to 8.8 conversion. Normalisation uses a one-bit-per-cycle shifter, so area stays small and latency is data-dependent.

## Interface
- EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1
- MAN_W, 10, stored fraction width (hidden bit is restored internally)
- INT_W, 8, integer bits of the output, including sign
- FRAC_W, 8, fractional bits of the output
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request pulse; samples flt_in
- flt_in  in  1+EXP_W+MAN_W  {sign, exponent, fraction}
- ack  out  1  level-high completion flag
- busy  out  1  high while a conversion is in progress
- fix_out  out  INT_W+FRAC_W  result, two's complement
- sat  out  1  the result was clamped

## Operation
- States: IDLE, DECODE, SHIFT, FIN.
- IDLE:
  - On start=1, latch flt_in, clear ack, set busy, go to DECODE.
  - start is also accepted while ack=1.
- DECODE computes e = exp − bias and classifies the input:
  - exp==0 (zero/subnormal): magnitude flushes to 0; go to FIN.
  - exp all-ones (Inf/NaN): saturate. Inf uses its sign; NaN gives positive max. Go to FIN.
  - e ≥ INT_W−1: saturate by sign; go to FIN.
  - Otherwise load the magnitude register with {1, fraction} and set s = e + FRAC_W − MAN_W.
  - Set k = |s| for a left shift (s>0). For a right shift, k = min(|s|, MAN_W+2).
  - If k==0 go to FIN, else go to SHIFT.
- SHIFT:
  - Shift the magnitude one bit per cycle, left if s>0, right if s<0.
  - Right shifts capture guard and sticky bits.
  - Decrement k; go to FIN when k reaches 1.
- FIN:
  - Truncate the magnitude toward zero (ROUND_EN changes this).
  - Negate if sign=1, write fix_out and sat.
  - Set ack, clear busy, return to IDLE.
- Saturation values: positive max = 0x7FFF (0 followed by all ones); negative = 0x8000 (1 followed by all zeros). sat=1 only for these clamped cases.
- Width rule: the magnitude register is INT_W+FRAC_W bits. Non-saturated inputs always have magnitude < 2^(INT_W−1), so there is no overflow.
- start while busy=1 is ignored; the in-flight conversion is unaffected.
- Reset at any time, including mid-SHIFT:
  - Returns to IDLE.
  - Clears ack, busy, sat and fix_out; the conversion is discarded.

## Timing
- Reset values: ack=0, busy=0, sat=0, fix_out=0.
- start is sampled at edge T0, and busy is high from T0+.
- DECODE occupies the cycle after T0, SHIFT takes k cycles, then FIN takes one cycle.
- ack and fix_out become valid together 2+k cycles after T0; special cases use k=0.
- Latency bounds with defaults: minimum 2 cycles; maximum 2+MAN_W+2 = 14 cycles.
- ack and fix_out hold until the next accepted start or reset.
- ack falls on the edge that accepts the new start.

## Configuration
- FLT2FIX_ROUND_EN defined: FIN rounds to nearest, ties to even, using guard, sticky and the LSB.
  - Rounding is applied before negation.
  - If rounding carries the magnitude past the representable range, saturate with sat=1.
  - Latency is unchanged.
- FLT2FIX_ROUND_EN undefined: guard and sticky are ignored; the result truncates toward zero.

## Test plan
- 0x3C00 (1.0): s=−2 → fix_out=0x0100, sat=0, ack 4 cycles after start. 0x4300 (3.5) → 0x0380.
- 0xC100 (−2.5) → 0xFD80. 0x5400 (64.0, s=+4) → 0x4000, ack 6 cycles after start.
- Saturation:
  - 0x5B00 → 0x7FFF, sat=1; 0xDB00 → 0x8000, sat=1; both with ack 2 cycles after start.
  - 0x7C00 → 0x7FFF; 0xFE00 (NaN) → 0x7FFF.
- Small values:
  - 0x1C00 → 0x0001; 0x0000 and 0x8000 → 0x0000.
  - 0x1A00 → 0x0000 without ROUND_EN, 0x0001 with it.
  - 0x1800 (tie) → 0x0000 either way.
- start pulsed again mid-SHIFT is ignored, and the first result is intact. Back-to-back start while ack=1 drops ack on that edge.
- Reset asserted during SHIFT of 0x5400: ack, busy and fix_out go to 0 immediately. A following 0x3C00 conversion returns 0x0100.

Source files
------------

// File: rtl/flt2fix_seq.sv
// flt2fix_seq: sequential packed-float to two's-complement fixed-point converter.
// Define FLT2FIX_ROUND_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module flt2fix_seq #(
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned MAN_W  = 10,
    parameter int unsigned INT_W  = 8,
    parameter int unsigned FRAC_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [EXP_W+MAN_W:0]    flt_in,
    output logic                    ack,
    output logic                    busy,
    output logic [INT_W+FRAC_W-1:0] fix_out,
    output logic                    sat
);
    localparam int unsigned FLT_W = 1 + EXP_W + MAN_W;
    localparam int unsigned OUT_W = INT_W + FRAC_W;
    localparam int unsigned KW    = $clog2(OUT_W + MAN_W + 3);
    localparam int          BIAS  = int'((1 << (EXP_W - 1)) - 1);
    localparam int          RMAX  = int'(MAN_W) + 2;
    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_FIN    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [FLT_W-1:0] flt_q, flt_d;
    logic [OUT_W-1:0] mag_q, mag_d;
    logic [KW-1:0]    k_q, k_d;
    logic             left_q, left_d;
    logic             guard_q, guard_d;
    logic             sticky_q, sticky_d;
    logic             sign_q, sign_d;
    logic             sat_pend_q, sat_pend_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic [OUT_W-1:0] fix_q, fix_d;
    logic             sat_q, sat_d;

    logic [EXP_W-1:0] exp_c;
    logic [MAN_W-1:0] frac_c;
    int               e_c, s_c, k_c;
    logic [OUT_W:0]   rnd_c;
    logic             ovf_c;

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        flt_d      = flt_q;
        mag_d      = mag_q;
        k_d        = k_q;
        left_d     = left_q;
        guard_d    = guard_q;
        sticky_d   = sticky_q;
        sign_d     = sign_q;
        sat_pend_d = sat_pend_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        fix_d      = fix_q;
        sat_d      = sat_q;

        exp_c  = flt_q[FLT_W-2 -: EXP_W];
        frac_c = flt_q[MAN_W-1:0];
        e_c    = int'(exp_c) - BIAS;
        s_c    = e_c + int'(FRAC_W) - int'(MAN_W);
        if (s_c > 0)          k_c = s_c;
        else if (-s_c > RMAX) k_c = RMAX;
        else                  k_c = -s_c;

`ifdef FLT2FIX_ROUND_EN
        rnd_c = {1'b0, mag_q} + (OUT_W+1)'(guard_q & (sticky_q | mag_q[0]));
`else
        rnd_c = {1'b0, mag_q};
`endif
        // Anything reaching the sign bit no longer fits the positive range
        ovf_c = rnd_c[OUT_W] | rnd_c[OUT_W-1];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    flt_d   = flt_in;
                    ack_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                sign_d     = flt_q[FLT_W-1];
                mag_d      = '0;
                guard_d    = 1'b0;
                sticky_d   = 1'b0;
                sat_pend_d = 1'b0;
                left_d     = 1'b0;
                k_d        = '0;
                state_d    = S_FIN;
                if (exp_c == '0) begin
                    mag_d = '0;
                end else if (exp_c == '1) begin
                    // NaN clamps positive, infinity keeps its sign
                    sat_pend_d = 1'b1;
                    if (frac_c != '0) sign_d = 1'b0;
                end else if (e_c >= int'(INT_W) - 1) begin
                    sat_pend_d = 1'b1;
                end else begin
                    mag_d  = OUT_W'({1'b1, frac_c});
                    left_d = (s_c > 0);
                    k_d    = KW'(k_c);
                    if (k_c != 0) state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    mag_d    = mag_q >> 1;
                    guard_d  = mag_q[0];
                    sticky_d = sticky_q | guard_q;
                end
                k_d = k_q - KW'(1);
                if (k_q == KW'(1)) state_d = S_FIN;
            end
            default: begin
                if (sat_pend_q || ovf_c) begin
                    fix_d = sign_q ? SAT_NEG : SAT_POS;
                    sat_d = 1'b1;
                end else begin
                    fix_d = sign_q ? OUT_W'(-rnd_c[OUT_W-1:0]) : rnd_c[OUT_W-1:0];
                    sat_d = 1'b0;
                end
                ack_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            flt_q      <= '0;
            mag_q      <= '0;
            k_q        <= '0;
            left_q     <= 1'b0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            sign_q     <= 1'b0;
            sat_pend_q <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            fix_q      <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            flt_q      <= flt_d;
            mag_q      <= mag_d;
            k_q        <= k_d;
            left_q     <= left_d;
            guard_q    <= guard_d;
            sticky_q   <= sticky_d;
            sign_q     <= sign_d;
            sat_pend_q <= sat_pend_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            fix_q      <= fix_d;
            sat_q      <= sat_d;
        end
    end

    assign ack     = ack_q;
    assign busy    = busy_q;
    assign fix_out = fix_q;
    assign sat     = sat_q;

endmodule
